// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity modes: the parity bit is XOR(data) XOR mode
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period down-counter. tick marks the last cycle of a bit;
//                the counter reloads from prescaler on tick or on restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int PWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [PWIDTH-1:0] prescaler,
    output logic              tick
);

    logic [PWIDTH-1:0] count;

    assign tick = (count == '0);

    // Count down; reload so each bit lasts prescaler+1 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= prescaler;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_reader
//  Description : UART transmitter draining a show-ahead byte FIFO. Pops one
//                word per frame: start, DWIDTH data bits LSB first, optional
//                parity, 1 or 2 stop bits. Frames chain with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int PWIDTH     = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [PWIDTH-1:0] prescaler,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int              CW        = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0]   LAST_DATA = CW'(DWIDTH - 1);
    localparam logic [CW-1:0]   LAST_STOP = CW'(STOP_BITS - 1);
    localparam logic            PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_e       state;
    uart_state_e       state_next;
    logic [CW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] shreg;
    logic [DWIDTH-1:0] shreg_next;
    logic              parity_bit;
    logic              tx_next;
    logic              tick;
    logic              last_stop;
    logic              load;

    // Final cycle of the final stop bit
    assign last_stop = (state == STOP) && tick && (bit_cnt == LAST_STOP);

    // A new word is taken from idle or back-to-back at the end of a frame;
    // held off during reset so nothing is popped while the block is cleared
    assign load = rst_n && ((state == IDLE) || last_stop) && en && !fifo_empty;

    // The counter is held at the reload value while idle so the first start
    // bit gets a full period counted from the load edge
    uart_baud_cnt #(
        .PWIDTH    (PWIDTH)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (state == IDLE),
        .prescaler (prescaler),
        .tick      (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every non-idle state advances on the baud tick
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) state_next = START;
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick && (bit_cnt == LAST_DATA)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (last_stop) state_next = load ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs and next line level; tx is registered from the upcoming state
    always_comb begin
        fifo_rd    = load;
        frame_done = last_stop;
        busy       = (state != IDLE);

        shreg_next = shreg;
        if (load) begin
            shreg_next = fifo_rdata;
        end else if ((state == DATA) && tick) begin
            shreg_next = shreg >> 1;
        end

        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = parity_bit;
            default: tx_next = 1'b1;
        endcase
    end

    // Datapath: shift register, latched parity, bit counter and line driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            tx         <= 1'b1;
        end else begin
            shreg <= shreg_next;
            tx    <= tx_next;
            if (load) begin
                parity_bit <= (^fifo_rdata) ^ PAR_MODE;
            end
            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (tick && ((state == DATA) || (state == STOP))) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_fifo_reader
//  Description : Scoreboard bench. Stimulus pushes bytes into FIFO models and
//                the expected frame into a queue; per-instance monitors pop
//                and compare each frame as the DUT transmits it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_reader;

    typedef struct {
        logic [15:0] bits;   // line levels, index 0 = start bit
        int          n;      // number of bit periods
        int          p;      // prescaler used for this frame
        bit          chain;  // must start in the final cycle of the previous frame
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] prescaler;

    // FIFO model A feeds the default instance, B feeds both parity instances
    logic [7:0] mem_a [0:15];
    logic [7:0] mem_b [0:15];
    int         wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    logic       empty_a, empty_b;
    logic [7:0] rdata_a, rdata_b;

    logic [2:0] tx_v, busy_v, rd_v, done_v, empty_v;

    frame_t q0[$], q1[$], q2[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cyc    = 0;

    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);
    assign rdata_a = mem_a[rd_a[3:0]];
    assign rdata_b = mem_b[rd_b[3:0]];
    assign empty_v = {empty_b, empty_b, empty_a};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_v[0]) rd_a <= rd_a + 1;
        if (rd_v[1]) rd_b <= rd_b + 1;
    end

    uart_tx_fifo_reader #(.DWIDTH(8), .PWIDTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .prescaler(prescaler),
        .fifo_empty(empty_a), .fifo_rdata(rdata_a), .fifo_rd(rd_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

    uart_tx_fifo_reader #(.DWIDTH(8), .PWIDTH(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_pe (
        .clk(clk), .rst_n(rst_n), .en(en), .prescaler(prescaler),
        .fifo_empty(empty_b), .fifo_rdata(rdata_b), .fifo_rd(rd_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

    uart_tx_fifo_reader #(.DWIDTH(8), .PWIDTH(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_po (
        .clk(clk), .rst_n(rst_n), .en(en), .prescaler(prescaler),
        .fifo_empty(empty_b), .fifo_rdata(rdata_b), .fifo_rd(rd_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t mk_frame(input logic [7:0] d, input bit pe, input bit odd,
                                        input int sb, input int p, input bit chain);
        frame_t f;
        int     k;
        f.bits = '0;
        k = 1;                                   // bit 0 is the low start bit
        for (int i = 0; i < 8; i++) begin
            f.bits[k] = d[i];
            k++;
        end
        if (pe) begin
            f.bits[k] = (^d) ^ odd;
            k++;
        end
        for (int i = 0; i < sb; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n     = k;
        f.p     = p;
        f.chain = chain;
        return f;
    endfunction

    task automatic push_a(input logic [7:0] d, input bit chain);
        mem_a[wr_a[3:0]] = d;
        wr_a = wr_a + 1;
        q0.push_back(mk_frame(d, 1'b0, 1'b0, 1, int'(prescaler), chain));
    endtask

    task automatic push_b(input logic [7:0] d);
        mem_b[wr_b[3:0]] = d;
        wr_b = wr_b + 1;
        q1.push_back(mk_frame(d, 1'b1, 1'b0, 2, int'(prescaler), 1'b0));
        q2.push_back(mk_frame(d, 1'b1, 1'b1, 2, int'(prescaler), 1'b0));
    endtask

    task automatic pop_exp(input int idx, output frame_t f, output bit ok);
        ok = 1'b0;
        f  = '{bits: '0, n: 0, p: 0, chain: 1'b0};
        case (idx)
            0: if (q0.size() > 0) begin f = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin f = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin f = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Watches one instance: idle line checks, then bit-by-bit frame compare
    task automatic monitor(input int idx);
        frame_t f;
        bit     ok;
        bit     aborted;
        int     last_end = -100;
        forever begin
            @(negedge clk);
            check("idle_tx", 32'(tx_v[idx]), 32'd1);
            check("idle_busy", 32'(busy_v[idx]), 32'd0);
            check("idle_done", 32'(done_v[idx]), 32'd0);
            if (!rst_n) check("rst_rd", 32'(rd_v[idx]), 32'd0);
            while (rst_n && rd_v[idx]) begin
                check("rd_when_empty", 32'(empty_v[idx]), 32'd0);
                pop_exp(idx, f, ok);
                if (!ok) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pop: inst %0d popped with no frame queued (cycle %0d)", idx, cyc);
                    break;
                end
                if (f.chain) check("chain_gap", 32'(cyc), 32'(last_end));
                aborted = 1'b0;
                for (int b = 0; b < f.n && !aborted; b++) begin
                    for (int c = 0; c <= f.p && !aborted; c++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            check("rst_mid_tx", 32'(tx_v[idx]), 32'd1);
                            check("rst_mid_busy", 32'(busy_v[idx]), 32'd0);
                            aborted = 1'b1;
                        end else begin
                            check($sformatf("tx_i%0d_b%0d", idx, b), 32'(tx_v[idx]), 32'(f.bits[b]));
                            check("frame_busy", 32'(busy_v[idx]), 32'd1);
                            check("frame_done", 32'(done_v[idx]),
                                  32'((b == f.n - 1) && (c == f.p)));
                        end
                    end
                end
                if (aborted) break;
                last_end = cyc;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rd_v[0] && k < bound);
        if (!rd_v[0]) check("timeout_rd", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(wr_a == rd_a && wr_b == rd_b && busy_v == 3'b000) && k < bound);
        check("timeout_idle", 32'(busy_v), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        rst_n     = 1'b0;
        en        = 1'b0;
        prescaler = 16'd3;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_v), 32'h7);
        check("reset_busy", 32'(busy_v), 32'h0);
        check("reset_rd", 32'(rd_v), 32'h0);
        check("reset_done", 32'(done_v), 32'h0);
        step();
        rst_n = 1'b1;

        // Single byte, 4 cycles per bit
        step();
        en = 1'b1;
        push_a(8'hA5, 1'b0);
        wait_idle(200);

        // Back-to-back frames with no idle gap
        step();
        prescaler = 16'd1;
        push_a(8'h00, 1'b0);
        push_a(8'hFF, 1'b1);
        wait_idle(200);

        // Even and odd parity, two stop bits
        step();
        prescaler = 16'd2;
        push_b(8'h07);
        wait_idle(200);

        // Empty FIFO with transmit enabled: line stays idle
        repeat (100) step();
        check("empty_no_pop", 32'(rd_a), 32'(wr_a));

        // Disabled with words queued: nothing popped until enabled
        en        = 1'b0;
        prescaler = 16'd1;
        push_a(8'h11, 1'b0);
        push_a(8'h22, 1'b1);
        push_a(8'h33, 1'b1);
        repeat (50) step();
        check("en0_no_pop", 32'(wr_a - rd_a), 32'd3);
        en = 1'b1;
        wait_idle(400);

        // Enable dropped mid-frame: frame finishes, next word stays queued
        step();
        push_a(8'h5A, 1'b0);
        push_a(8'hC3, 1'b0);
        wait_rd(20);
        repeat (6) @(posedge clk);
        #1;
        en = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy_v[0] && k < 100);
        check("en_drop_finish", 32'(busy_v[0]), 32'd0);
        repeat (10) step();
        check("en_drop_empty", 32'(empty_a), 32'd0);
        check("en_drop_count", 32'(wr_a - rd_a), 32'd1);
        en = 1'b1;
        wait_idle(200);

        // Reset during data bit 3; popped word is lost, next word sent whole
        step();
        prescaler = 16'd2;
        push_a(8'h30, 1'b0);
        push_a(8'hC3, 1'b0);
        wait_rd(20);
        repeat (13) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_async_tx", 32'(tx_v[0]), 32'd1);
        check("rst_async_busy", 32'(busy_v[0]), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_idle(200);

        repeat (5) step();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
